// File: rtl/accelerator_calculus_pkg.sv
// Shared definitions for the calculus accelerators: the control state
// encoding, the integration rule selector and common zero/one constants.
package accelerator_calculus_pkg;

  // Control FSM states shared by the streaming calculus blocks.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Integration rule selector, latched from MODE_IN at START.
  localparam logic EULER     = 1'b0;
  localparam logic TRAPEZOID = 1'b1;

  // Width-agnostic constants; users cast them to their own widths.
  localparam int unsigned ZERO_CONTROL = 0;
  localparam int unsigned ONE_CONTROL  = 1;
  localparam int unsigned ZERO_DATA    = 0;

endpackage

// File: rtl/accelerator_fixed_integration_step.sv
// One fixed-point integration step: given the previous and current sample,
// the step size and the running accumulator, produce the next accumulator.
// Optional feature macro: ACCELERATOR_MATRIX_INTEGRATION_SATURATE_EN
//   defined   -> results outside the signed DATA_SIZE range are clamped and
//                overflow_o reports the clamp;
//   undefined -> results wrap modulo 2^DATA_SIZE and overflow_o is 0.
module accelerator_fixed_integration_step
  import accelerator_calculus_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int FRAC_SIZE = 32
) (
  input  logic                        mode_i,
  input  logic                        first_i,
  input  logic signed [DATA_SIZE-1:0] prev_i,
  input  logic signed [DATA_SIZE-1:0] sample_i,
  input  logic signed [DATA_SIZE-1:0] period_i,
  input  logic signed [DATA_SIZE-1:0] acc_i,
  output logic        [DATA_SIZE-1:0] acc_o,
  output logic                        overflow_o
);

  // Wide enough for (x_prev + x) * P with sign, plus the accumulator add.
  localparam int WW = 2 * DATA_SIZE + 2;

  logic signed [WW-1:0] x_w;
  logic signed [WW-1:0] prev_w;
  logic signed [WW-1:0] p_w;
  logic signed [WW-1:0] acc_w;
  logic signed [WW-1:0] sum_w;
  logic signed [WW-1:0] prod_w;
  logic signed [WW-1:0] inc_w;
  logic signed [WW-1:0] full_w;

  // Full-precision increment and new integral; a row start discards history.
  always_comb begin
    x_w    = {{(WW-DATA_SIZE){sample_i[DATA_SIZE-1]}}, sample_i};
    prev_w = {{(WW-DATA_SIZE){prev_i[DATA_SIZE-1]}}, prev_i};
    p_w    = {{(WW-DATA_SIZE){period_i[DATA_SIZE-1]}}, period_i};
    acc_w  = {{(WW-DATA_SIZE){acc_i[DATA_SIZE-1]}}, acc_i};
    sum_w  = x_w;
    if (mode_i == TRAPEZOID) begin
      sum_w = prev_w + x_w;
    end
    prod_w = sum_w * p_w;
    if (mode_i == TRAPEZOID) begin
      inc_w = prod_w >>> (FRAC_SIZE + 1);
    end else begin
      inc_w = prod_w >>> FRAC_SIZE;
    end
    if (first_i) begin
      full_w = (mode_i == TRAPEZOID) ? '0 : inc_w;
    end else begin
      full_w = acc_w + inc_w;
    end
  end

`ifdef ACCELERATOR_MATRIX_INTEGRATION_SATURATE_EN
  localparam logic signed [WW-1:0] MAX_W = {{(WW-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_W = {{(WW-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  // Clamp to the signed DATA_SIZE range and flag the clamp.
  always_comb begin
    acc_o      = full_w[DATA_SIZE-1:0];
    overflow_o = 1'b0;
    if (full_w > MAX_W) begin
      acc_o      = MAX_W[DATA_SIZE-1:0];
      overflow_o = 1'b1;
    end else if (full_w < MIN_W) begin
      acc_o      = MIN_W[DATA_SIZE-1:0];
      overflow_o = 1'b1;
    end
  end
`else
  // Upper bits are dropped: the result wraps modulo 2^DATA_SIZE.
  logic [WW-DATA_SIZE-1:0] unused_hi;
  assign unused_hi  = full_w[WW-1:DATA_SIZE];
  assign acc_o      = full_w[DATA_SIZE-1:0];
  assign overflow_o = 1'b0;
`endif

endmodule

// File: rtl/accelerator_matrix_integration_stream.sv
// Streaming row-wise integrator: accepts a SIZE_I x SIZE_J matrix in
// row-major order and emits the running integral along each row two cycles
// after each accepted sample (Euler or trapezoid rule, fixed point).
// Optional feature macro: ACCELERATOR_MATRIX_INTEGRATION_SATURATE_EN
// (saturating arithmetic with a sticky OVERFLOW flag; wraps when undefined).
//
// Handshake: a sample transfers on a rising edge where DATA_IN_VALID and
// DATA_IN_READY are both high; DATA_IN_READY is high only in RUN and does not
// depend on DATA_IN_VALID. Outputs have no backpressure: each *_ENABLE is a
// one-cycle pulse qualifying DATA_OUT.
module accelerator_matrix_integration_stream
  import accelerator_calculus_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FRAC_SIZE    = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    MODE_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0]    PERIOD_IN,
  input  logic                    DATA_IN_VALID,
  output logic                    DATA_IN_READY,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    DATA_OUT_SCALAR_ENABLE,
  output logic                    DATA_OUT_VECTOR_ENABLE,
  output logic                    DATA_OUT_MATRIX_ENABLE,
  output logic                    OVERFLOW
);

  localparam logic [CONTROL_SIZE-1:0] C_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
  localparam logic [CONTROL_SIZE-1:0] C_ONE  = CONTROL_SIZE'(ONE_CONTROL);
  localparam logic [DATA_SIZE-1:0]    D_ZERO = DATA_SIZE'(ZERO_DATA);

  state_t state_q, state_d;
  logic   start_take;
  logic   accept;
  logic   row_end;
  logic   mat_end;

  // Operation parameters latched at START.
  logic                    mode_q;
  logic [CONTROL_SIZE-1:0] size_i_q;
  logic [CONTROL_SIZE-1:0] size_j_q;
  logic [DATA_SIZE-1:0]    period_q;
  logic [CONTROL_SIZE-1:0] i_q;
  logic [CONTROL_SIZE-1:0] j_q;

  // Stage 1: accepted sample plus its position flags.
  logic                 s1_valid_q;
  logic [DATA_SIZE-1:0] s1_data_q;
  logic                 s1_first_q;
  logic                 s1_row_end_q;
  logic                 s1_mat_end_q;

  // Stage 2: integration state and registered outputs.
  logic [DATA_SIZE-1:0] acc_q;
  logic [DATA_SIZE-1:0] prev_q;
  logic [DATA_SIZE-1:0] data_out_q;
  logic                 scalar_q;
  logic                 vector_q;
  logic                 matrix_q;
  logic                 ready_q;
  logic                 overflow_q;

  logic [DATA_SIZE-1:0] step_acc;
  logic                 step_ovf;

  assign accept  = (state_q == RUN) && DATA_IN_VALID;
  assign row_end = (j_q == size_j_q - C_ONE);
  assign mat_end = row_end && (i_q == size_i_q - C_ONE);

  // Next-state and handshake decode for the control FSM.
  always_comb begin
    state_d       = state_q;
    start_take    = 1'b0;
    DATA_IN_READY = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          start_take = 1'b1;
          if ((SIZE_I_IN == C_ZERO) || (SIZE_J_IN == C_ZERO)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        DATA_IN_READY = 1'b1;
        if (DATA_IN_VALID && mat_end) begin
          state_d = DRAIN;
        end
      end
      // The final sample sits in stage 1 here and moves to stage 2 on this
      // edge, so DONE lines up with the MATRIX_ENABLE pulse.
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch operation parameters at START and walk the i/j counters on accepts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q   <= EULER;
      size_i_q <= C_ZERO;
      size_j_q <= C_ZERO;
      period_q <= D_ZERO;
      i_q      <= C_ZERO;
      j_q      <= C_ZERO;
    end else if (start_take) begin
      mode_q   <= MODE_IN;
      size_i_q <= SIZE_I_IN;
      size_j_q <= SIZE_J_IN;
      period_q <= PERIOD_IN;
      i_q      <= C_ZERO;
      j_q      <= C_ZERO;
    end else if (accept) begin
      if (row_end) begin
        j_q <= C_ZERO;
        i_q <= i_q + C_ONE;
      end else begin
        j_q <= j_q + C_ONE;
      end
    end
  end

  // Stage 1: capture the accepted sample and where it sits in the matrix.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= D_ZERO;
      s1_first_q   <= 1'b0;
      s1_row_end_q <= 1'b0;
      s1_mat_end_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q    <= DATA_IN;
        s1_first_q   <= (j_q == C_ZERO);
        s1_row_end_q <= row_end;
        s1_mat_end_q <= mat_end;
      end
    end
  end

  accelerator_fixed_integration_step #(
    .DATA_SIZE (DATA_SIZE),
    .FRAC_SIZE (FRAC_SIZE)
  ) u_step (
    .mode_i     (mode_q),
    .first_i    (s1_first_q),
    .prev_i     (prev_q),
    .sample_i   (s1_data_q),
    .period_i   (period_q),
    .acc_i      (acc_q),
    .acc_o      (step_acc),
    .overflow_o (step_ovf)
  );

  // Stage 2: update the integral, publish it with its enable pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q      <= D_ZERO;
      prev_q     <= D_ZERO;
      data_out_q <= D_ZERO;
      scalar_q   <= 1'b0;
      vector_q   <= 1'b0;
      matrix_q   <= 1'b0;
    end else begin
      scalar_q <= s1_valid_q;
      vector_q <= s1_valid_q && s1_row_end_q;
      matrix_q <= s1_valid_q && s1_mat_end_q;
      if (s1_valid_q) begin
        acc_q      <= step_acc;
        prev_q     <= s1_data_q;
        data_out_q <= step_acc;
      end
    end
  end

  // READY follows DONE by one register; OVERFLOW is sticky until START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ready_q <= (state_q == DONE);
      if (start_take) begin
        overflow_q <= 1'b0;
      end else if (s1_valid_q && step_ovf) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign READY                  = ready_q;
  assign DATA_OUT               = data_out_q;
  assign DATA_OUT_SCALAR_ENABLE = scalar_q;
  assign DATA_OUT_VECTOR_ENABLE = vector_q;
  assign DATA_OUT_MATRIX_ENABLE = matrix_q;
  assign OVERFLOW               = overflow_q;

endmodule

// File: tb/tb_accelerator_matrix_integration_stream.sv
// Self-checking bench for the streaming matrix integrator (Q8.8, 16-bit).
module tb_accelerator_matrix_integration_stream;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          RST;
  logic          START;
  logic          READY;
  logic          MODE_IN;
  logic [CW-1:0] SIZE_I_IN;
  logic [CW-1:0] SIZE_J_IN;
  logic [DW-1:0] PERIOD_IN;
  logic          DATA_IN_VALID;
  logic          DATA_IN_READY;
  logic [DW-1:0] DATA_IN;
  logic [DW-1:0] DATA_OUT;
  logic          SCALAR_EN;
  logic          VECTOR_EN;
  logic          MATRIX_EN;
  logic          OVERFLOW;

  accelerator_matrix_integration_stream #(
    .DATA_SIZE    (DW),
    .CONTROL_SIZE (CW),
    .FRAC_SIZE    (FW)
  ) dut (
    .CLK                    (clk),
    .RST                    (RST),
    .START                  (START),
    .READY                  (READY),
    .MODE_IN                (MODE_IN),
    .SIZE_I_IN              (SIZE_I_IN),
    .SIZE_J_IN              (SIZE_J_IN),
    .PERIOD_IN              (PERIOD_IN),
    .DATA_IN_VALID          (DATA_IN_VALID),
    .DATA_IN_READY          (DATA_IN_READY),
    .DATA_IN                (DATA_IN),
    .DATA_OUT               (DATA_OUT),
    .DATA_OUT_SCALAR_ENABLE (SCALAR_EN),
    .DATA_OUT_VECTOR_ENABLE (VECTOR_EN),
    .DATA_OUT_MATRIX_ENABLE (MATRIX_EN),
    .OVERFLOW               (OVERFLOW)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [1:0]    exp_f_q[$];
  int            exp_cyc_q[$];
  logic [DW-1:0] mat[$];
  int            last_matrix_cyc = -1;
  int            start_cyc = 0;
  logic [DW-1:0] mon_d;
  logic [1:0]    mon_f;
  int            mon_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: row-wise integral from the arithmetic rules.
  task automatic model(input bit mode, input int si, input int sj,
                       input logic [DW-1:0] p, output bit ovf);
    longint y, t, x, xp, pl;
    logic [DW-1:0] w;
    ovf = 1'b0;
    pl  = longint'($signed(p));
    for (int i = 0; i < si; i++) begin
      y  = 0;
      xp = 0;
      for (int j = 0; j < sj; j++) begin
        x = longint'($signed(mat[i*sj+j]));
        if (!mode)        t = y + ((x * pl) >>> FW);
        else if (j == 0)  t = 0;
        else              t = y + (((xp + x) * pl) >>> (FW + 1));
`ifdef ACCELERATOR_MATRIX_INTEGRATION_SATURATE_EN
        if (t > 32767)       begin t = 32767;  ovf = 1'b1; end
        else if (t < -32768) begin t = -32768; ovf = 1'b1; end
`else
        w = t[DW-1:0];
        t = longint'($signed(w));
`endif
        y  = t;
        xp = x;
        w  = t[DW-1:0];
        exp_q.push_back(w);
        exp_f_q.push_back({(j == sj-1), (i == si-1) && (j == sj-1)});
      end
    end
  endtask

  // ---------------- monitor / checker ----------------
  always @(negedge clk) begin
    if (!RST && DATA_IN_VALID && DATA_IN_READY) exp_cyc_q.push_back(cyc);
    if (SCALAR_EN) begin
      chk("out_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_d = exp_q.pop_front();
        mon_f = exp_f_q.pop_front();
        mon_c = (exp_cyc_q.size() > 0) ? exp_cyc_q.pop_front() : -100;
        chk("data_out", DATA_OUT, mon_d);
        chk("vector_matrix_en", {VECTOR_EN, MATRIX_EN}, mon_f);
        chk("latency", cyc, mon_c + 2);
        if (MATRIX_EN) last_matrix_cyc = cyc;
      end
    end else begin
      chk("stray_enable", {VECTOR_EN, MATRIX_EN}, 2'b00);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input bit mode, input int si, input int sj, input logic [DW-1:0] p);
    MODE_IN   = mode;
    SIZE_I_IN = CW'(si);
    SIZE_J_IN = CW'(sj);
    PERIOD_IN = p;
    START     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    START     = 1'b0;
    MODE_IN   = 1'($urandom);
    SIZE_I_IN = CW'($urandom_range(1, 5));
    SIZE_J_IN = CW'($urandom_range(1, 5));
    PERIOD_IN = DW'($urandom);
  endtask

  task automatic send_elem(input logic [DW-1:0] d);
    int waited = 0;
    DATA_IN_VALID = 1'b1;
    DATA_IN       = d;
    @(negedge clk);
    while (DATA_IN_READY !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("din_ready", DATA_IN_READY, 1);
    @(posedge clk); #1;
    DATA_IN_VALID = 1'b0;
    DATA_IN       = DW'($urandom);
  endtask

  task automatic wait_ready(input bit zero_size);
    int w = 0;
    @(negedge clk);
    while (READY !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("ready_seen", READY, 1);
    chk("ready_cycle", cyc, zero_size ? start_cyc + 2 : last_matrix_cyc + 1);
    @(negedge clk);
    chk("ready_pulse_width", READY, 0);
    @(posedge clk); #1;
  endtask

  // gap_kind: 0 none, 1 gaps of 1 and 3 cycles, 2 random 0..3.
  task automatic run_op(input bit mode, input int si, input int sj, input logic [DW-1:0] p,
                        input int gap_kind, input bit poke_start);
    bit ovf;
    int gap;
    last_matrix_cyc = -1;
    model(mode, si, sj, p, ovf);
    do_start(mode, si, sj, p);
    for (int k = 0; k < si*sj; k++) begin
      gap = 0;
      if (gap_kind == 1) gap = (k % 4 == 1) ? 1 : ((k % 4 == 3) ? 3 : 0);
      if (gap_kind == 2) gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      if (poke_start && k == 1) begin
        START     = 1'b1;
        MODE_IN   = ~mode;
        SIZE_I_IN = CW'(1);
        SIZE_J_IN = CW'(1);
      end
      send_elem(mat[k]);
      START = 1'b0;
    end
    wait_ready(si*sj == 0);
    chk("overflow", OVERFLOW, ovf);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic fill_rand(input int n, input bit big);
    mat.delete();
    for (int k = 0; k < n; k++)
      mat.push_back(big ? DW'($urandom) : DW'($signed(12'($urandom))));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ovf_unused;
    int seen;
    RST = 1'b1; START = 1'b0; MODE_IN = 1'b0; SIZE_I_IN = '0; SIZE_J_IN = '0;
    PERIOD_IN = '0; DATA_IN_VALID = 1'b0; DATA_IN = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {READY, DATA_IN_READY, SCALAR_EN, VECTOR_EN, MATRIX_EN, OVERFLOW, DATA_OUT}, 0);
    @(posedge clk); #1;
    RST = 1'b0;
    @(posedge clk); #1;

    // Euler 1x3, P = 0.5
    mat = '{16'd256, 16'd512, 16'd768};
    run_op(1'b0, 1, 3, 16'd128, 0, 1'b0);
    // Trapezoid, same data
    mat = '{16'd256, 16'd512, 16'd768};
    run_op(1'b1, 1, 3, 16'd128, 0, 1'b0);
    // 2x2 Euler, P = 1.0, with VALID gaps of 1 and 3 cycles
    mat = '{16'd256, 16'd256, 16'd512, 16'd512};
    run_op(1'b0, 2, 2, 16'd256, 1, 1'b0);
    // Range limit on the second output
    mat = '{16'd32512, 16'd32512};
    run_op(1'b0, 1, 2, 16'd256, 0, 1'b0);
    // Empty matrices
    mat.delete();
    run_op(1'b0, 2, 0, 16'd256, 0, 1'b0);
    run_op(1'b1, 0, 3, 16'd256, 0, 1'b0);
    // START during RUN is ignored
    fill_rand(6, 1'b0);
    run_op(1'b0, 2, 3, DW'($urandom_range(0, 600)), 0, 1'b1);

    // Randomized operations
    for (int r = 0; r < 8; r++) begin
      int si = $urandom_range(1, 3);
      int sj = $urandom_range(1, 4);
      fill_rand(si*sj, r[0]);
      run_op(1'($urandom), si, sj, DW'($urandom_range(0, 1023)) - 16'd300, 2, 1'b0);
    end

    // Reset mid-row
    fill_rand(12, 1'b0);
    last_matrix_cyc = -1;
    model(1'b0, 3, 4, 16'd200, ovf_unused);
    do_start(1'b0, 3, 4, 16'd200);
    for (int k = 0; k < 6; k++) send_elem(mat[k]);
    RST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_reset_outputs", {READY, DATA_IN_READY, SCALAR_EN, VECTOR_EN, MATRIX_EN, OVERFLOW, DATA_OUT}, 0);
    #1;
    exp_q.delete(); exp_f_q.delete(); exp_cyc_q.delete();
    @(posedge clk); #1;
    RST = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (READY) seen = 1;
    end
    chk("no_ready_after_reset", seen, 0);
    @(posedge clk); #1;
    fill_rand(6, 1'b0);
    run_op(1'b1, 2, 3, 16'd256, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
